// File: rtl/mem_resp_router.sv
// Routes in-order memory read responses back to the fetch or load requester,
// using a tag FIFO that records the source of every accepted request.
module mem_resp_router #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_src,
  output logic                       req_ready,
  input  logic                       resp_valid,
  input  logic [N-1:0]               resp_data,
  output logic                       resp_ready,
  input  logic                       flush,
  output logic                       inst_valid,
  output logic [N-1:0]               inst_data,
  input  logic                       inst_ready,
  output logic                       load_valid,
  output logic [N-1:0]               load_data,
  input  logic                       load_ready,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       err
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DEPTH-1:0] src_r;
  logic [DEPTH-1:0] kill_r;
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      pending_r;
  logic             err_r;

  logic             out_full_r;
  logic             out_src_r;
  logic [N-1:0]     inst_data_r;
  logic [N-1:0]     load_data_r;

  logic             push_s;
  logic             pop_s;
  logic             drain_s;
  logic             resp_ready_s;
  logic             head_src_s;
  logic             head_kill_s;
  logic             deliver_s;
  logic             empty_s;

  // Handshake strobes; a fetch head is treated as killed during a flush cycle.
  always_comb begin
    empty_s      = (pending_r == {(AW+1){1'b0}});
    push_s       = req_valid && req_ready;
    drain_s      = out_full_r && (out_src_r ? load_ready : inst_ready);
    resp_ready_s = !out_full_r || drain_s;
    pop_s        = resp_valid && resp_ready_s && !empty_s;
    head_src_s   = src_r[head_r];
    head_kill_s  = kill_r[head_r] || (flush && !head_src_s);
    deliver_s    = pop_s && !head_kill_s;
  end

  // Tag FIFO, occupancy count and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_r     <= {DEPTH{1'b0}};
      kill_r    <= {DEPTH{1'b0}};
      head_r    <= {AW{1'b0}};
      tail_r    <= {AW{1'b0}};
      pending_r <= {(AW+1){1'b0}};
      err_r     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush && !src_r[i]) begin
          kill_r[i] <= 1'b1;
        end
      end
      // A same-cycle push overrides the flush kill: it belongs to the new path.
      if (push_s) begin
        src_r[tail_r]  <= req_src;
        kill_r[tail_r] <= 1'b0;
        tail_r         <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   pending_r <= pending_r + CNT_ONE;
        2'b01:   pending_r <= pending_r - CNT_ONE;
        default: pending_r <= pending_r;
      endcase
      if (resp_valid && empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Output register: refill has priority over drain, drain over flush clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_full_r  <= 1'b0;
      out_src_r   <= 1'b0;
      inst_data_r <= {N{1'b0}};
      load_data_r <= {N{1'b0}};
    end else begin
      if (deliver_s) begin
        out_full_r <= 1'b1;
        out_src_r  <= head_src_s;
        if (head_src_s) begin
          load_data_r <= resp_data;
        end else begin
          inst_data_r <= resp_data;
        end
      end else if (drain_s) begin
        out_full_r <= 1'b0;
      end else if (flush && out_full_r && !out_src_r) begin
        out_full_r <= 1'b0;
      end else begin
        out_full_r <= out_full_r;
      end
    end
  end

  assign req_ready  = (pending_r != FULL_CNT);
  assign resp_ready = resp_ready_s;
  assign inst_valid = out_full_r && !out_src_r;
  assign load_valid = out_full_r && out_src_r;
  assign inst_data  = inst_data_r;
  assign load_data  = load_data_r;
  assign pending    = pending_r;
  assign err        = err_r;

endmodule

// File: tb/tb_mem_resp_router.sv
// Directed bench for mem_resp_router with hand-computed expectations.
module tb_mem_resp_router;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_src;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_ready;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [2:0]  pending;
  logic        err;

  int errors = 0;
  int checks = 0;

  mem_resp_router #(.N(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_src(req_src), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .flush(flush),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .pending(pending), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_src = 1'b0; resp_valid = 1'b0;
    resp_data = 32'h0; flush = 1'b0; inst_ready = 1'b0; load_ready = 1'b0;
    #12;
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_load_valid", 32'(load_valid), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    rst = 1'b0;
    tick();

    // Basic routing: sources 0,1,0 with words 0x11,0x22,0x33
    req_valid = 1'b1; req_src = 1'b0; tick();
    req_src = 1'b1; tick();
    req_src = 1'b0; tick();
    req_valid = 1'b0;
    chk("t1_pending3", 32'(pending), 32'h3);
    inst_ready = 1'b1; load_ready = 1'b1;
    resp_valid = 1'b1; resp_data = 32'h11; tick();
    chk("t1_inst_valid_11", 32'(inst_valid), 32'h1);
    chk("t1_inst_data_11", inst_data, 32'h11);
    chk("t1_pending2", 32'(pending), 32'h2);
    resp_data = 32'h22; tick();
    chk("t1_load_valid_22", 32'(load_valid), 32'h1);
    chk("t1_load_data_22", load_data, 32'h22);
    chk("t1_inst_valid_off", 32'(inst_valid), 32'h0);
    chk("t1_inst_data_hold", inst_data, 32'h11);
    resp_data = 32'h33; tick();
    chk("t1_inst_valid_33", 32'(inst_valid), 32'h1);
    chk("t1_inst_data_33", inst_data, 32'h33);
    chk("t1_pending0", 32'(pending), 32'h0);
    resp_valid = 1'b0; tick();
    chk("t1_inst_drained", 32'(inst_valid), 32'h0);

    // FIFO full, pop, push+pop
    req_valid = 1'b1; req_src = 1'b1;
    tick(); tick(); tick(); tick();
    req_valid = 1'b0;
    chk("t2_pending4", 32'(pending), 32'h4);
    chk("t2_req_ready_low", 32'(req_ready), 32'h0);
    resp_valid = 1'b1; resp_data = 32'hA0; tick();
    chk("t2_pending3", 32'(pending), 32'h3);
    chk("t2_req_ready_high", 32'(req_ready), 32'h1);
    chk("t2_load_data_a0", load_data, 32'hA0);
    req_valid = 1'b1; req_src = 1'b1; resp_data = 32'hA1; tick();
    chk("t2_pushpop_pending", 32'(pending), 32'h3);
    chk("t2_load_data_a1", load_data, 32'hA1);
    req_valid = 1'b0;
    resp_data = 32'hA2; tick();
    resp_data = 32'hA3; tick();
    resp_data = 32'hA4; tick();
    chk("t2_pending_empty", 32'(pending), 32'h0);
    chk("t2_load_data_a4", load_data, 32'hA4);
    resp_valid = 1'b0; tick();
    chk("t2_load_drained", 32'(load_valid), 32'h0);

    // Backpressure on the fetch sink
    req_valid = 1'b1; req_src = 1'b0; tick(); tick();
    req_valid = 1'b0; inst_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'hAB; tick();
    resp_data = 32'hCD;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", 32'(inst_valid), 32'h1);
      chk("t3_hold_data", inst_data, 32'hAB);
      chk("t3_resp_ready_low", 32'(resp_ready), 32'h0);
      chk("t3_hold_pending", 32'(pending), 32'h1);
      tick();
    end
    inst_ready = 1'b1; #1;
    chk("t3_resp_ready_drain", 32'(resp_ready), 32'h1);
    tick();
    chk("t3_refill_valid", 32'(inst_valid), 32'h1);
    chk("t3_refill_data", inst_data, 32'hCD);
    chk("t3_pending0", 32'(pending), 32'h0);
    resp_valid = 1'b0; tick();
    chk("t3_drained", 32'(inst_valid), 32'h0);

    // Flush kills outstanding fetches, not loads
    req_valid = 1'b1; req_src = 1'b0; tick(); tick();
    req_src = 1'b1; tick();
    req_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h1; tick();
    chk("t4_drop1", 32'(inst_valid), 32'h0);
    chk("t4_pending2", 32'(pending), 32'h2);
    resp_data = 32'h2; tick();
    chk("t4_drop2", 32'(inst_valid), 32'h0);
    resp_data = 32'h3; tick();
    chk("t4_load_valid", 32'(load_valid), 32'h1);
    chk("t4_load_data", load_data, 32'h3);
    chk("t4_pending0", 32'(pending), 32'h0);
    resp_valid = 1'b0; tick();

    // Flush clears held fetch word; same-cycle request survives
    req_valid = 1'b1; req_src = 1'b0; tick();
    req_valid = 1'b0; inst_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h55; tick();
    resp_valid = 1'b0;
    chk("t5_hold_55", inst_data, 32'h55);
    chk("t5_valid_55", 32'(inst_valid), 32'h1);
    flush = 1'b1; req_valid = 1'b1; req_src = 1'b0; tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("t5_flush_clear", 32'(inst_valid), 32'h0);
    chk("t5_pending1", 32'(pending), 32'h1);
    inst_ready = 1'b1;
    resp_valid = 1'b1; resp_data = 32'h66; tick();
    chk("t5_post_valid", 32'(inst_valid), 32'h1);
    chk("t5_post_data", inst_data, 32'h66);
    resp_valid = 1'b0; tick();

    // Protocol error and async reset
    resp_valid = 1'b1; resp_data = 32'h99; tick();
    resp_valid = 1'b0;
    chk("t6_err", 32'(err), 32'h1);
    chk("t6_no_inst", 32'(inst_valid), 32'h0);
    chk("t6_no_load", 32'(load_valid), 32'h0);
    chk("t6_pending0", 32'(pending), 32'h0);
    tick();
    chk("t6_err_sticky", 32'(err), 32'h1);
    req_valid = 1'b1; req_src = 1'b1; tick(); tick();
    req_valid = 1'b0; load_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h77; tick();
    chk("t6_load_77", 32'(load_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_load_valid", 32'(load_valid), 32'h0);
    chk("t6_rst_load_data", load_data, 32'h0);
    chk("t6_rst_inst_data", inst_data, 32'h0);
    chk("t6_rst_pending", 32'(pending), 32'h0);
    chk("t6_rst_err", 32'(err), 32'h0);
    resp_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_resp_router.md
Name: mem_resp_router

Overview:
- Response-side counterpart of the unified-memory request arbiter. The arbiter merges instruction-fetch and data requests onto the single memory port; this block routes each in-order memory response back to its requester.
- Records the source of every accepted request in an in-order tag FIFO. Each returning read word is steered to either the IF stage or the MEM-stage load path through a registered output with valid/ready handshakes.
- Supports flush of outstanding fetch responses on branch redirect.

Parameters:
- N, 32, data width of memory response and sink data.
- DEPTH, 4, maximum outstanding requests; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  arbiter issuing a request to memory this cycle.
- req_src  in  1  requester of that request: 0 = fetch, 1 = data (load).
- req_ready  out  1  tag FIFO can accept a request; arbiter must not issue when low.
- resp_valid  in  1  memory returning a read word, in request order.
- resp_data  in  N  read word.
- resp_ready  out  1  router accepts the response this cycle.
- flush  in  1  discard all outstanding fetch responses.
- inst_valid  out  1  fetch word available.
- inst_data  out  N  fetch word.
- inst_ready  in  1  IF stage accepts the word.
- load_valid  out  1  load word available.
- load_data  out  N  load word.
- load_ready  in  1  MEM stage accepts the word.
- pending  out  log2(DEPTH)+1  number of tag FIFO entries.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, immediate):
  - inst_valid = load_valid = 0; inst_data = load_data = 0.
  - FIFO empty: pending = 0, head/tail pointers = 0.
  - err = 0; output register empty.
- Tag FIFO:
  - DEPTH entries of {src, kill}; circular with wrapping pointers.
  - Push {req_src, 0} when req_valid && req_ready.
  - req_ready = (pending != DEPTH); there is no same-cycle pop bypass.
  - Pop when resp_valid && resp_ready && FIFO non-empty.
  - Simultaneous push and pop: pending unchanged, both pointers advance.
- Output register: one entry {full, src, data}.
  - inst_valid = full && src == 0; load_valid = full && src == 1.
  - Data is driven on the selected sink only; the other sink's data holds its last value.
  - drain = full && (src ? load_ready : inst_ready).
  - resp_ready = !full || drain, so a full register can refill in the same cycle it drains.
- Accepted response, head entry not killed:
  - Output register loads {head.src, resp_data}; full = 1 next cycle.
  - Latency is exactly 1 cycle from resp accept to valid.
- Accepted response, head entry killed:
  - Word is dropped; the entry is popped; the output register is unaffected.
- Output register hold:
  - Valid and data are held stable until drained.
  - Drain with no new load: full = 0 next cycle.
- flush:
  - Sets kill on every FIFO entry with src == 0 that is present at the start of the cycle.
  - A request pushed in the same cycle is not killed; it belongs to the post-flush path.
  - If the response accepted in the flush cycle targets fetch, it is dropped.
  - If the output register holds fetch data, it is cleared (full = 0 next cycle) unless a load word is written in that cycle.
  - Load entries and load data are never affected by flush.
- Protocol error:
  - resp_valid while pending == 0: response ignored, no state change, err set to 1 until reset.
  - With DEPTH = 4 and req_valid asserted while req_ready is low, the request is not recorded. This is the arbiter's fault; the router does not set err for it.
- Reset mid-transaction: all outstanding tags are lost. Memory responses arriving after reset then raise err, which is accepted behaviour; the system resets the memory together with the router.

Test Plan:
- Reset, then issue requests src 0,1,0; return words 0x11,0x22,0x33 with both readies high -> inst_valid with 0x11 at t+1, load_valid with 0x22, inst_valid with 0x33; pending goes 3->0.
- Issue 4 requests with no response -> pending = 4, req_ready = 0. Pop one -> req_ready = 1 the next cycle. Push and pop in the same cycle -> pending unchanged.
- inst_ready held low for 3 cycles with an output word 0xAB -> inst_valid/inst_data stable and resp_ready = 0 while a second response waits. Raise inst_ready -> 0xAB drains and the second word loads in the same cycle.
- Issue src 0,0,1 outstanding, pulse flush, then return 0x1,0x2,0x3 -> no inst_valid; load_valid with 0x3; pending returns to 0.
- Flush while output holds fetch 0x55 and a same-cycle request with src 0 is issued -> inst_valid drops next cycle. That request's later response 0x66 is delivered.
- resp_valid with pending = 0 -> err = 1 and no valid asserted. Assert rst asynchronously mid-stream -> all outputs, pending and err clear immediately.
